// File: rtl/pipe_id_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_id_issue_pkg
// Brief    : Shared widths, register constants and the E-stage control bundle.
// Revision : 1.0
// ============================================================================
package pipe_id_issue_pkg;

    localparam int RW  = 5;
    localparam int ACW = 4;

    localparam logic [RW-1:0] REG_ZERO = 5'd0;
    localparam logic [RW-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic           valid;
        logic           wreg;
        logic           m2reg;
        logic           wmem;
        logic           jal;
        logic           aluimm;
        logic           shift;
        logic [ACW-1:0] aluc;
        logic [RW-1:0]  rn;
    } ectl_t;

    // A bubble writes nothing and carries zeroed fields.
    localparam ectl_t c_ectl_bubble = '0;

    function automatic logic reg_match(input logic we, input logic [RW-1:0] rn,
                                       input logic [RW-1:0] src);
        return we && (rn == src) && (src != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fwd_sel
// Brief    : Youngest-first operand forwarding mux (EXE, MEM, WB, register file).
// Revision : 1.0
// ============================================================================
module pipe_fwd_sel
    import pipe_id_issue_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [RW-1:0] i_src,
    input  logic [DW-1:0] i_rf,
    input  logic          i_ewreg,
    input  logic          i_em2reg,
    input  logic [RW-1:0] i_ern,
    input  logic [DW-1:0] i_ealu,
    input  logic          i_mwreg,
    input  logic          i_mm2reg,
    input  logic [RW-1:0] i_mrn,
    input  logic [DW-1:0] i_malu,
    input  logic [DW-1:0] i_mmo,
    input  logic          i_wwreg,
    input  logic [RW-1:0] i_wrn,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_data
);

    // A load in EXE has no data yet; the stall lets MEM forwarding pick it up.
    always_comb begin
        o_data = i_rf;
        if (reg_match(i_ewreg, i_ern, i_src) && !i_em2reg) begin
            o_data = i_ealu;
        end else if (reg_match(i_mwreg, i_mrn, i_src)) begin
            o_data = i_mm2reg ? i_mmo : i_malu;
        end else if (reg_match(i_wwreg, i_wrn, i_src)) begin
            o_data = i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_id_issue.sv
`default_nettype none
// ============================================================================
// Module   : pipe_id_issue
// Brief    : ID/EXE register with forwarding, load-use stall and stall counter.
// Revision : 1.0
// ============================================================================
module pipe_id_issue
    import pipe_id_issue_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dvalid,
    input  logic [DW-1:0] da,
    input  logic [DW-1:0] db,
    input  logic [DW-1:0] dimm,
    input  logic [DW-1:0] dpc4,
    input  logic [4:0]    drs,
    input  logic [4:0]    drt,
    input  logic          duse_rs,
    input  logic          duse_rt,
    input  logic [4:0]    drn,
    input  logic [3:0]    daluc,
    input  logic          daluimm,
    input  logic          dshift,
    input  logic          djal,
    input  logic          dwreg,
    input  logic          dm2reg,
    input  logic          dwmem,
    input  logic          dflush,
    input  logic [DW-1:0] ealu,
    input  logic [4:0]    ern,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mmo,
    input  logic [4:0]    mrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [DW-1:0] wdata,
    input  logic [4:0]    wrn,
    input  logic          wwreg,
    output logic [DW-1:0] ea,
    output logic [DW-1:0] eb,
    output logic [DW-1:0] eimm,
    output logic [DW-1:0] epc4,
    output logic [4:0]    ern0,
    output logic [3:0]    ealuc,
    output logic          ealuimm,
    output logic          eshift,
    output logic          ejal,
    output logic          ewreg,
    output logic          em2reg,
    output logic          ewmem,
    output logic          evalid,
    output logic          dstall,
    output logic [CW-1:0] stall_cnt
);

    ectl_t         r_ctl;
    logic [DW-1:0] r_a, r_b, r_imm, r_pc4;
    logic [CW-1:0] r_stall_cnt;

    ectl_t         w_dctl;
    logic [DW-1:0] w_fwd_a, w_fwd_b;
    logic          w_hazard, w_issue;

    pipe_fwd_sel #(.DW(DW)) u_fwd_rs (
        .i_src   (drs),
        .i_rf    (da),
        .i_ewreg (r_ctl.wreg),
        .i_em2reg(r_ctl.m2reg),
        .i_ern   (ern),
        .i_ealu  (ealu),
        .i_mwreg (mwreg),
        .i_mm2reg(mm2reg),
        .i_mrn   (mrn),
        .i_malu  (malu),
        .i_mmo   (mmo),
        .i_wwreg (wwreg),
        .i_wrn   (wrn),
        .i_wdata (wdata),
        .o_data  (w_fwd_a)
    );

    pipe_fwd_sel #(.DW(DW)) u_fwd_rt (
        .i_src   (drt),
        .i_rf    (db),
        .i_ewreg (r_ctl.wreg),
        .i_em2reg(r_ctl.m2reg),
        .i_ern   (ern),
        .i_ealu  (ealu),
        .i_mwreg (mwreg),
        .i_mm2reg(mm2reg),
        .i_mrn   (mrn),
        .i_malu  (malu),
        .i_mmo   (mmo),
        .i_wwreg (wwreg),
        .i_wrn   (wrn),
        .i_wdata (wdata),
        .o_data  (w_fwd_b)
    );

    always_comb begin
        w_hazard = dvalid && r_ctl.m2reg && r_ctl.wreg && (ern != REG_ZERO) &&
                   ((duse_rs && (drs == ern)) || (duse_rt && (drt == ern)));
        w_issue  = dvalid && !dflush && !w_hazard;

        w_dctl        = c_ectl_bubble;
        w_dctl.valid  = 1'b1;
        w_dctl.wreg   = dwreg;
        w_dctl.m2reg  = dm2reg;
        w_dctl.wmem   = dwmem;
        w_dctl.jal    = djal;
        w_dctl.aluimm = daluimm;
        w_dctl.shift  = dshift;
        w_dctl.aluc   = daluc;
        w_dctl.rn     = drn;
    end

    assign dstall = w_hazard && !dflush;

    always_ff @(posedge clk) begin
        if (rst || !w_issue) begin
            r_ctl <= c_ectl_bubble;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_pc4 <= '0;
        end else begin
            r_ctl <= w_dctl;
            r_a   <= w_fwd_a;
            r_b   <= w_fwd_b;
            r_imm <= dimm;
            r_pc4 <= dpc4;
        end
    end

    // Saturating count so long-running profiles never alias back to small values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (dstall && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ea        = r_a;
    assign eb        = r_b;
    assign eimm      = r_imm;
    assign epc4      = r_pc4;
    assign ern0      = r_ctl.rn;
    assign ealuc     = r_ctl.aluc;
    assign ealuimm   = r_ctl.aluimm;
    assign eshift    = r_ctl.shift;
    assign ejal      = r_ctl.jal;
    assign ewreg     = r_ctl.wreg;
    assign em2reg    = r_ctl.m2reg;
    assign ewmem     = r_ctl.wmem;
    assign evalid    = r_ctl.valid;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_id_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_id_issue
// Brief    : Directed plus randomized bench against a behavioural issue model.
// Revision : 1.0
// ============================================================================
module tb_pipe_id_issue;
    import pipe_id_issue_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dvalid, duse_rs, duse_rt, daluimm, dshift, djal, dwreg, dm2reg, dwmem, dflush;
    logic [DW-1:0] da, db, dimm, dpc4, ealu, malu, mmo, wdata;
    logic [4:0]    drs, drt, drn, ern, mrn, wrn;
    logic [3:0]    daluc;
    logic          mwreg, mm2reg, wwreg;
    logic [DW-1:0] ea, eb, eimm, epc4;
    logic [4:0]    ern0;
    logic [3:0]    ealuc;
    logic          ealuimm, eshift, ejal, ewreg, em2reg, ewmem, evalid, dstall;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Expected E-stage contents.
    logic          m_valid, m_wreg, m_m2reg, m_wmem, m_jal, m_aluimm, m_shift;
    logic [3:0]    m_aluc;
    logic [4:0]    m_rn;
    logic [DW-1:0] m_a, m_b, m_imm, m_pc4;
    int            m_cnt;

    always #5 clk = ~clk;

    pipe_id_issue #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .dvalid(dvalid), .da(da), .db(db), .dimm(dimm), .dpc4(dpc4),
        .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt), .drn(drn), .daluc(daluc),
        .daluimm(daluimm), .dshift(dshift), .djal(djal), .dwreg(dwreg), .dm2reg(dm2reg),
        .dwmem(dwmem), .dflush(dflush), .ealu(ealu), .ern(ern), .malu(malu), .mmo(mmo),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .wdata(wdata), .wrn(wrn), .wwreg(wwreg),
        .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0), .ealuc(ealuc),
        .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ewreg(ewreg), .em2reg(em2reg),
        .ewmem(ewmem), .evalid(evalid), .dstall(dstall), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest producer wins; a load still in EXE cannot supply data.
    function automatic logic [DW-1:0] model_operand(input logic [4:0] s, input logic [DW-1:0] rf);
        if (s == 5'd0) return rf;
        if (m_wreg && ern == s && !m_m2reg) return ealu;
        if (mwreg && mrn == s) return mm2reg ? mmo : malu;
        if (wwreg && wrn == s) return wdata;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return dvalid && m_m2reg && m_wreg && ern != 5'd0 &&
               ((duse_rs && drs == ern) || (duse_rt && drt == ern));
    endfunction

    task automatic clear_inputs();
        rst = 0; dvalid = 0; duse_rs = 0; duse_rt = 0; daluimm = 0; dshift = 0; djal = 0;
        dwreg = 0; dm2reg = 0; dwmem = 0; dflush = 0; da = 0; db = 0; dimm = 0; dpc4 = 0;
        drs = 0; drt = 0; drn = 0; daluc = 0; ealu = 0; ern = 0; malu = 0; mmo = 0; mrn = 0;
        mwreg = 0; mm2reg = 0; wdata = 0; wrn = 0; wwreg = 0;
    endtask

    task automatic check_e();
        chk("ea", 64'(ea), 64'(m_a));
        chk("eb", 64'(eb), 64'(m_b));
        chk("imm_pc4", {eimm, epc4}, {m_imm, m_pc4});
        chk("ctl", 64'({evalid, ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern0}),
            64'({m_valid, m_wreg, m_m2reg, m_wmem, m_jal, m_aluimm, m_shift, m_aluc, m_rn}));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // One clock: inputs already driven while clk is low.
    task automatic cyc();
        logic          hz, st, iss;
        logic [DW-1:0] na, nb;
        #1;
        hz  = model_hazard();
        st  = hz && !dflush;
        chk("dstall", 64'(dstall), 64'(st));
        iss = !rst && dvalid && !dflush && !hz;
        na  = model_operand(drs, da);
        nb  = model_operand(drt, db);
        @(posedge clk);
        #1;
        if (rst) m_cnt = 0;
        else if (st && m_cnt < (1 << CW) - 1) m_cnt++;
        if (iss) begin
            m_valid = 1; m_wreg = dwreg; m_m2reg = dm2reg; m_wmem = dwmem; m_jal = djal;
            m_aluimm = daluimm; m_shift = dshift; m_aluc = daluc; m_rn = drn;
            m_a = na; m_b = nb; m_imm = dimm; m_pc4 = dpc4;
        end else begin
            m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_jal = 0;
            m_aluimm = 0; m_shift = 0; m_aluc = 0; m_rn = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_pc4 = 0;
        end
        check_e();
        @(negedge clk);
    endtask

    task automatic issue_load(input logic [4:0] rd);
        dvalid = 1; dm2reg = 1; dwreg = 1; drn = rd; duse_rs = 0; duse_rt = 0; dflush = 0;
        mwreg = 0; wwreg = 0; ern = 0;
        cyc();
    endtask

    task automatic randomize_inputs();
        rst     = ($urandom_range(0, 60) == 0);
        dvalid  = ($urandom_range(0, 7) != 0);
        dflush  = ($urandom_range(0, 7) == 0);
        duse_rs = $urandom_range(0, 1); duse_rt = $urandom_range(0, 1);
        daluimm = $urandom_range(0, 1); dshift = $urandom_range(0, 1);
        djal    = ($urandom_range(0, 5) == 0); dwreg = ($urandom_range(0, 3) != 0);
        dm2reg  = ($urandom_range(0, 2) == 0); dwmem = ($urandom_range(0, 4) == 0);
        da = $urandom; db = $urandom; dimm = $urandom; dpc4 = $urandom;
        drs = 5'($urandom_range(0, 3)); drt = 5'($urandom_range(0, 3));
        drn = 5'($urandom_range(0, 3)); daluc = 4'($urandom);
        ealu = $urandom; malu = $urandom; mmo = $urandom; wdata = $urandom;
        ern  = ($urandom_range(0, 1) == 1) ? (m_jal ? REG_RA : m_rn) : 5'($urandom_range(0, 3));
        mrn  = 5'($urandom_range(0, 3)); wrn = 5'($urandom_range(0, 3));
        mwreg = $urandom_range(0, 1); mm2reg = $urandom_range(0, 1); wwreg = $urandom_range(0, 1);
    endtask

    initial begin
        clear_inputs();
        m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_jal = 0; m_aluimm = 0;
        m_shift = 0; m_aluc = 0; m_rn = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc4 = 0; m_cnt = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_evalid", 64'(evalid), 64'd0);
        chk("reset_dstall", 64'(dstall), 64'd0);
        check_e();
        @(negedge clk);
        rst = 0;

        // Plain add, no hazards.
        dvalid = 1; da = 5; db = 7; drs = 1; drt = 2; duse_rs = 1; duse_rt = 1; drn = 3; dwreg = 1;
        cyc();
        chk("add_ea", 64'(ea), 64'd5);
        chk("add_eb", 64'(eb), 64'd7);
        chk("add_evalid", 64'(evalid), 64'd1);

        // EXE forward, then $0 passthrough.
        ern = 8; ealu = 32'h1234; drs = 8;
        cyc();
        chk("exe_fwd", 64'(ea), 64'h1234);
        drs = 0; da = 32'h55; ern = 0;
        cyc();
        chk("r0_pass", 64'(ea), 64'h55);

        // Forwarding priority on r9.
        drt = 9; duse_rt = 1; db = 32'h77; ern = 9; ealu = 1;
        mwreg = 1; mrn = 9; malu = 2; mmo = 4; wwreg = 1; wrn = 9; wdata = 3;
        cyc();
        chk("prio_exe", 64'(eb), 64'd1);
        ern = 0;
        cyc();
        chk("prio_mem", 64'(eb), 64'd2);
        mm2reg = 1;
        cyc();
        chk("prio_mmo", 64'(eb), 64'd4);
        mm2reg = 0;

        // Load-use: stall once, then MEM forwards the loaded value.
        issue_load(5'd10);
        dm2reg = 0; ern = 10; drs = 10; duse_rs = 1; da = 32'h99;
        #1;
        chk("lu_dstall", 64'(dstall), 64'd1);
        cyc();
        chk("lu_bubble", 64'(evalid), 64'd0);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        mwreg = 1; mrn = 10; mm2reg = 1; mmo = 32'hABC;
        cyc();
        chk("lu_mmo", 64'(ea), 64'hABC);
        chk("lu_issue", 64'(evalid), 64'd1);

        // Flush during hazard.
        issue_load(5'd10);
        dm2reg = 0; ern = 10; drs = 10; duse_rs = 1; dflush = 1;
        #1;
        chk("flush_dstall", 64'(dstall), 64'd0);
        cyc();
        chk("flush_bubble", 64'(evalid), 64'd0);
        chk("flush_cnt", 64'(stall_cnt), 64'd1);
        dflush = 0;

        // Twenty forced stalls saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            issue_load(5'd10);
            dm2reg = 0; ern = 10; drs = 10; duse_rs = 1;
            cyc();
        end
        chk("sat_cnt", 64'(stall_cnt), 64'd15);

        // Reset mid-stream with a live instruction in ID.
        dvalid = 1; dwreg = 1; drn = 4; da = 32'h11; rst = 1; ern = 0; dm2reg = 0;
        cyc();
        chk("rst_ea", 64'(ea), 64'd0);
        chk("rst_evalid", 64'(evalid), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        rst = 0;

        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
